// File: rtl/fir_tap_pkg.sv
// Shared helpers for the FIR tap filters: accumulator sizing, output shift,
// saturation and coefficient slicing.
package fir_tap_pkg;

  // Widest accumulator any filter instance may pass to the saturation helper.
  localparam int unsigned SatW = 128;

  function automatic int unsigned acc_width(input int unsigned width, input int unsigned taps);
    return 2 * width + $clog2(taps);
  endfunction

  function automatic int unsigned shift_amt(input int unsigned in_frac, input int unsigned out_frac);
    return 2 * in_frac - out_frac;
  endfunction

  function automatic int unsigned coeff_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

  // Clamp a sign-extended value to the range of an out_w-bit signed number.
  function automatic logic signed [SatW-1:0] sat_to_width(input logic signed [SatW-1:0] val,
                                                           input int unsigned out_w);
    logic signed [SatW-1:0] max_v;
    logic signed [SatW-1:0] min_v;
    max_v = (SatW'(1) << (out_w - 1)) - SatW'(1);
    min_v = ~max_v;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end
    return val;
  endfunction

endpackage

// File: rtl/fir_tap_sat_round.sv
// Output rescaling stage: optional round-half-up, arithmetic right shift, saturation.
// Rounding is enabled by defining FIR_ROUND_EN.
module fir_tap_sat_round
  import fir_tap_pkg::*;
#(
  parameter int unsigned ACC_WIDTH         = 37,
  parameter int unsigned SHIFT             = 14,
  parameter int unsigned OUTPUT_DATA_WIDTH = 16
) (
  input  logic signed [ACC_WIDTH-1:0]         acc_i,
  output logic signed [OUTPUT_DATA_WIDTH-1:0] result_o
);

  // One guard bit so the rounding constant can never wrap the accumulator.
  localparam int unsigned RndW   = ACC_WIDTH + 1;
  localparam int unsigned RndPos = (SHIFT > 0) ? SHIFT - 1 : 0;
`ifdef FIR_ROUND_EN
  localparam logic [RndW-1:0] RndConst = (SHIFT > 0) ? (RndW'(1) << RndPos) : '0;
`else
  localparam logic [RndW-1:0] RndConst = '0;
`endif

  logic signed [RndW-1:0] acc_ext;
  logic signed [RndW-1:0] acc_rnd;
  logic signed [RndW-1:0] acc_shr;

  always_comb begin
    acc_ext  = {acc_i[ACC_WIDTH-1], acc_i};
    acc_rnd  = acc_ext + $signed(RndConst);
    acc_shr  = acc_rnd >>> SHIFT;
    result_o = OUTPUT_DATA_WIDTH'(sat_to_width(SatW'(acc_shr), OUTPUT_DATA_WIDTH));
  end

endmodule

// File: rtl/fir_tap_filter.sv
// Direct-form fully parallel FIR with run-time coefficients and sample enable.
// Define FIR_ROUND_EN to round half-up instead of truncating at the output.
module fir_tap_filter
  import fir_tap_pkg::*;
#(
  parameter int unsigned INPUT_DATA_WIDTH       = 16,
  parameter int unsigned INPUT_DATA_FRAC_WIDTH  = 14,
  parameter int unsigned OUTPUT_DATA_WIDTH      = 16,
  parameter int unsigned OUTPUT_DATA_FRAC_WIDTH = 14,
  parameter int unsigned FILTER_TAPS            = 26
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [INPUT_DATA_WIDTH*FILTER_TAPS-1:0]   coeff_vector,
  input  logic signed [INPUT_DATA_WIDTH-1:0]        data_in,
  input  logic                                      sample_en,
  output logic signed [OUTPUT_DATA_WIDTH-1:0]       data_out,
  output logic                                      sample_valid
);

  localparam int unsigned W        = INPUT_DATA_WIDTH;
  localparam int unsigned AccWidth = acc_width(W, FILTER_TAPS);
  localparam int unsigned Shift    = shift_amt(INPUT_DATA_FRAC_WIDTH, OUTPUT_DATA_FRAC_WIDTH);

  logic signed [W-1:0]                 taps_q [FILTER_TAPS];
  logic                                capture_q;
  logic signed [W-1:0]                 mac_coeff;
  logic signed [2*W-1:0]               mac_prod;
  logic signed [AccWidth-1:0]          acc_sum;
  logic signed [OUTPUT_DATA_WIDTH-1:0] y_sat;
  logic signed [OUTPUT_DATA_WIDTH-1:0] data_out_q;
  logic                                valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < FILTER_TAPS; k++) begin
        taps_q[k] <= '0;
      end
      capture_q <= 1'b0;
    end else begin
      capture_q <= sample_en;
      if (sample_en) begin
        taps_q[0] <= data_in;
        for (int unsigned k = 1; k < FILTER_TAPS; k++) begin
          taps_q[k] <= taps_q[k-1];
        end
      end
    end
  end

  // Full-width products summed into an accumulator sized so it cannot overflow.
  always_comb begin
    acc_sum   = '0;
    mac_coeff = '0;
    mac_prod  = '0;
    for (int unsigned k = 0; k < FILTER_TAPS; k++) begin
      mac_coeff = coeff_vector[coeff_lo(k, W) +: W];
      mac_prod  = mac_coeff * taps_q[k];
      acc_sum   = acc_sum + AccWidth'(mac_prod);
    end
  end

  fir_tap_sat_round #(
    .ACC_WIDTH        (AccWidth),
    .SHIFT            (Shift),
    .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH)
  ) u_sat_round (
    .acc_i   (acc_sum),
    .result_o(y_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= capture_q;
      if (capture_q) begin
        data_out_q <= y_sat;
      end
    end
  end

  assign data_out     = data_out_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_fir_tap_filter.sv
// Self-checking bench for fir_tap_filter: directed impulse/step/saturation/reset
// cases plus randomized traffic against an arithmetic reference model.
module tb_fir_tap_filter;

  localparam int W     = 16;
  localparam int TAPS  = 26;
  localparam int OUTW  = 16;
  localparam int SHIFT = 2 * 14 - 14;

  logic                       tb_clk = 1'b0;
  logic                       rst;
  logic [W*TAPS-1:0]          coeff_vector;
  logic signed [W-1:0]        data_in;
  logic                       sample_en;
  logic signed [OUTW-1:0]     data_out;
  logic                       sample_valid;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: coefficients, accepted-sample history (newest first), output regs.
  int     h    [TAPS];
  int     hist [TAPS];
  bit     pend;
  longint exp_out;
  bit     exp_valid;
  longint strobes[$];

  int h_proto [TAPS] = '{0, -4, -2, 2, 2, -3, -4, 5, 6, -8, -11, 19, 57, 57, 19, -11, -8, 6, 5,
                         -4, -3, 2, 2, -2, -4, 0};
  int imp_tbl [TAPS] = '{0, -3, -2, 1, 1, -2, -3, 3, 3, -5, -7, 11, 34, 34, 11, -7, -5, 3, 3,
                         -3, -2, 1, 1, -2, -3, 0};

  fir_tap_filter dut (
    .clk         (tb_clk),
    .rst         (rst),
    .coeff_vector(coeff_vector),
    .data_in     (data_in),
    .sample_en   (sample_en),
    .data_out    (data_out),
    .sample_valid(sample_valid)
  );

  always #5 tb_clk = ~tb_clk;

  function automatic longint model_y();
    longint acc = 0;
    for (int k = 0; k < TAPS; k++) acc += longint'(h[k]) * longint'(hist[k]);
`ifdef FIR_ROUND_EN
    acc += longint'(1) << (SHIFT - 1);
`endif
    acc = acc >>> SHIFT;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_coeffs();
    for (int k = 0; k < TAPS; k++) coeff_vector[k*W +: W] = h[k][W-1:0];
  endtask

  // One clock: drive inputs, advance the model across the edge, compare outputs.
  task automatic cycle(input bit en, input int din, input bit r);
    sample_en = en;
    data_in   = din[W-1:0];
    rst       = r;
    @(posedge tb_clk);
    #1;
    if (r) begin
      for (int k = 0; k < TAPS; k++) hist[k] = 0;
      pend = 0; exp_out = 0; exp_valid = 0;
    end else begin
      exp_valid = pend;
      if (pend) exp_out = model_y();
      if (en) begin
        for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = din;
      end
      pend = en;
    end
    check("valid", longint'(sample_valid), longint'(exp_valid));
    check("data_out", longint'(data_out), exp_out);
    if (sample_valid) strobes.push_back(longint'(data_out));
  endtask

  task automatic do_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 0);
  endtask

  // Impulse of 10000, one accepted sample every 'gap' cycles, 28 accepted samples total.
  task automatic run_impulse(input int gap);
    do_reset();
    strobes.delete();
    for (int i = 0; i < TAPS + 2; i++) begin
      cycle(1, (i == 0) ? 10000 : 0, 0);
      for (int g = 1; g < gap; g++) cycle(0, 0, 0);
    end
    cycle(0, 0, 0);
    check("impulse_strobes", longint'(strobes.size()), longint'(TAPS + 2));
    if (strobes.size() == TAPS + 2) begin
`ifdef FIR_ROUND_EN
      check("impulse_ctr0", strobes[12], 35);
      check("impulse_ctr1", strobes[13], 35);
`else
      for (int i = 0; i < TAPS; i++) check("impulse_tbl", strobes[i], longint'(imp_tbl[i]));
`endif
      check("impulse_tail", strobes[TAPS], 0);
    end
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; data_in = '0; coeff_vector = '0;
    pend = 0; exp_out = 0; exp_valid = 0;
    for (int k = 0; k < TAPS; k++) begin h[k] = h_proto[k]; hist[k] = 0; end
    load_coeffs();
    do_reset();
    check("reset_out", longint'(data_out), 0);

    run_impulse(2);   // toggling enable
    run_impulse(5);   // 1-in-5 enable gaps
    run_impulse(1);   // full throughput

    // Reset in the middle of an impulse response discards history.
    do_reset();
    cycle(1, 10000, 0);
    for (int i = 0; i < 12; i++) cycle(i % 2 == 1, 0, 0);
    cycle(0, 0, 1);
    check("midrst_out", longint'(data_out), 0);
    check("midrst_valid", longint'(sample_valid), 0);
    for (int i = 0; i < 60; i++) cycle(i % 2 == 0, 0, 0);

    // Step response settles at sum(h)*10000 >> 14.
    do_reset();
    for (int i = 0; i < 30; i++) begin cycle(1, 10000, 0); cycle(0, 10000, 0); end
    check("step_final", longint'(data_out), 72);

    // Saturation with all coefficients at 1.0.
    for (int k = 0; k < TAPS; k++) h[k] = 16384;
    load_coeffs();
    do_reset();
    for (int i = 0; i < 28; i++) cycle(1, 16383, 0);
    cycle(0, 0, 0);
    check("sat_pos", longint'(data_out), 32767);
    for (int i = 0; i < 28; i++) cycle(1, -16384, 0);
    cycle(0, 0, 0);
    check("sat_neg", longint'(data_out), -32768);

    // Randomized traffic: random coefficients, data, enables and occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      for (int k = 0; k < TAPS; k++) h[k] = int'($urandom_range(0, 65535)) - 32768;
      if (blk % 2 == 1) for (int k = 0; k < TAPS; k++) h[k] = h[k] / 64;
      load_coeffs();
      for (int i = 0; i < 80; i++) begin
        cycle($urandom_range(0, 2) != 0, int'($urandom_range(0, 65535)) - 32768,
              $urandom_range(0, 63) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
